// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute-stage ALU with valid/ready input and a 2-entry result FIFO
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_alu_control,
  input  logic [WIDTH-1:0] in_src_a,
  input  logic [WIDTH-1:0] in_src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal
);
  localparam int EW = WIDTH + 3;
  logic [WIDTH-1:0] sum, diff, res;
  logic             add_ov, sub_ov, slt, ovf, ill, push, pop;
  logic [EW-1:0]    entry, head;
  logic [EW-1:0]    mem_q [2];
  logic [EW-1:0]    mem_d [2];
  logic             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]       cnt_q, cnt_d;

  assign in_ready  = rst_n && (cnt_q != 2'd2);
  assign out_valid = cnt_q != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Compute result and flags for the operation presented at the input
  always_comb begin
    sum    = in_src_a + in_src_b;
    diff   = in_src_a - in_src_b;
    add_ov = (in_src_a[WIDTH-1] == in_src_b[WIDTH-1]) && (sum[WIDTH-1] != in_src_a[WIDTH-1]);
    sub_ov = (in_src_a[WIDTH-1] != in_src_b[WIDTH-1]) && (diff[WIDTH-1] != in_src_a[WIDTH-1]);
    slt    = diff[WIDTH-1] ^ sub_ov;
    res    = in_alu_control == 3'b000 ? sum :
             in_alu_control == 3'b001 ? diff :
             in_alu_control == 3'b010 ? in_src_a & in_src_b :
             in_alu_control == 3'b011 ? in_src_a | in_src_b :
             in_alu_control == 3'b101 ? {{(WIDTH-1){1'b0}}, slt} : '0;
    ovf    = in_alu_control == 3'b000 ? add_ov : in_alu_control == 3'b001 ? sub_ov : 1'b0;
    ill    = in_alu_control[2] && (in_alu_control != 3'b101);
    entry  = {res, res == '0, ovf, ill};
  end

  // FIFO next state: write at wptr on push, advance rptr on pop
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = entry;
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // FIFO state registers; reset discards every stored entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = out_valid ? mem_q[rptr_q] : '0;
  assign {out_result, out_zero, out_overflow, out_illegal} = head;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks against a queue-based reference model
module tb_alu_exec_stage;
  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        i;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_alu_control = 3'b0;
  logic [31:0] in_src_a = '0;
  logic [31:0] in_src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_illegal;

  int   n_chk = 0;
  int   n_err = 0;
  int   accepted = 0;
  ent_t q[$];

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_control(in_alu_control), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    ent_t   e = '{r: '0, z: 1'b0, o: 1'b0, i: 1'b0};
    case (op)
      3'd0: begin s = sa + sb; e.r = a + b; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sa - sb; e.r = a - b; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
      default: e.i = 1'b1;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic check_outputs();
    ent_t h = '{r: '0, z: 1'b0, o: 1'b0, i: 1'b0};
    if (q.size() != 0) h = q[0];
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, rst_n && (q.size() < 2));
    chk("out_result", out_result, h.r);
    chk("out_zero", out_zero, h.z);
    chk("out_overflow", out_overflow, h.o);
    chk("out_illegal", out_illegal, h.i);
  endtask

  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic ordy);
    bit push, pop;
    in_valid = v; in_alu_control = op; in_src_a = a; in_src_b = b; out_ready = ordy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    push = in_valid && rst_n && (q.size() < 2);
    pop  = out_ready && (q.size() != 0);
    if (!rst_n) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin q.push_back(ref_op(op, a, b)); accepted++; end
    end
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    #12;
    check_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(1, 3'b000, 32'd5, 32'd7, 1);
    chk("add_5_7", out_result, 32'd12);
    chk("add_5_7_ovf", out_overflow, 1'b0);
    cycle(1, 3'b001, 32'd3, 32'd3, 1);
    chk("sub_zero", out_zero, 1'b1);
    cycle(1, 3'b000, 32'h7FFFFFFF, 32'd1, 1);
    chk("add_ovf_res", out_result, 32'h80000000);
    chk("add_ovf", out_overflow, 1'b1);
    cycle(1, 3'b101, 32'hFFFFFFFF, 32'd1, 1);
    chk("slt_neg", out_result, 32'd1);
    cycle(1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 1);
    chk("slt_ovf", out_result, 32'd1);
    cycle(1, 3'b101, 32'd1, 32'd1, 1);
    chk("slt_eq", out_result, 32'd0);
    chk("slt_eq_zero", out_zero, 1'b1);
    cycle(0, 3'b000, 0, 0, 1);
    accepted = 0;
    for (int i = 0; i < 4; i++) cycle(1, 3'b000, 32'd100 + i, 32'd1, 0);
    chk("stall_accepts", accepted, 2);
    chk("stall_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 3'b000, 0, 0, 1);
    cycle(1, 3'b000, 32'd9, 32'd9, 0);
    cycle(1, 3'b010, 32'hF0, 32'h3C, 1);
    chk("pushpop_res", out_result, 32'h30);
    chk("pushpop_cnt", q.size(), 1);
    for (int i = 0; i < 3; i++) begin
      op = (i == 0) ? 3'b100 : (i == 1) ? 3'b110 : 3'b111;
      cycle(1, op, 32'h1234, 32'h5678, 1);
      chk("illegal", out_illegal, 1'b1);
      chk("illegal_zero", out_zero, 1'b1);
      chk("illegal_res", out_result, 32'd0);
    end
    cycle(0, 3'b000, 0, 0, 1);
    cycle(1, 3'b000, 32'd1, 32'd2, 0);
    cycle(1, 3'b011, 32'd4, 32'd8, 0);
    #2 rst_n = 1'b0;
    #1 q.delete();
    check_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 3'b000, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      end else begin
        op = in_alu_control; a = in_src_a; b = in_src_b;
      end
      cycle(1'($urandom_range(0, 3) != 0), op, a, b, 1'($urandom_range(0, 2) != 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
